// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_ctrl
// Brief    : Pattern sequencer for the 6-LED driver (static/blink/chase/bounce)
//            with a programmable step prescaler. Optional PWM brightness gating
//            is enabled by defining LED_SEQ_BRIGHT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
    parameter int PER_W = 16,
    parameter int N_LED = 6
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_cfg_wr,
    input  logic [1:0]       in_cfg_mode,
    input  logic [N_LED-1:0] in_cfg_pattern,
    input  logic [PER_W-1:0] in_cfg_period,
    input  logic [3:0]       in_cfg_duty,
    output logic [N_LED-1:0] out_led_mem,
    output logic             out_tick
);

    typedef enum logic [1:0] {
        ST_STATIC = 2'b00,
        ST_BLINK  = 2'b01,
        ST_CHASE  = 2'b10,
        ST_BOUNCE = 2'b11
    } mode_e;

    localparam int         POS_W    = 3;
    localparam logic       DIR_UP   = 1'b0;
    localparam logic       DIR_DOWN = 1'b1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);

    mode_e             mode_q,    mode_d;
    logic [N_LED-1:0]  pattern_q, pattern_d;
    logic [PER_W-1:0]  period_q,  period_d;
    logic [3:0]        duty_q,    duty_d;
    logic [PER_W-1:0]  div_cnt_q, div_cnt_d;
    logic [N_LED-1:0]  seq_q,     seq_d;
    logic              phase_q,   phase_d;
    logic [POS_W-1:0]  pos_q,     pos_d;
    logic              dir_q,     dir_d;
    logic [N_LED-1:0]  led_q,     led_d;
    logic              tick_q,    tick_d;

    logic              step_due;
    logic [N_LED-1:0]  raw_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            mode_q    <= ST_STATIC;
            pattern_q <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            div_cnt_q <= '0;
            seq_q     <= '0;
            phase_q   <= 1'b0;
            pos_q     <= '0;
            dir_q     <= DIR_UP;
            led_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            div_cnt_q <= div_cnt_d;
            seq_q     <= seq_d;
            phase_q   <= phase_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            led_q     <= led_d;
            tick_q    <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: config write, prescaler, per-mode step
    // ------------------------------------------------------------------
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        period_d  = period_q;
        duty_d    = duty_q;
        div_cnt_d = div_cnt_q;
        seq_d     = seq_q;
        phase_d   = phase_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        tick_d    = 1'b0;

        step_due  = (period_q != '0) && (div_cnt_q == (period_q - PER_W'(1)));

        // A write restarts everything and swallows a coincident tick.
        if (in_cfg_wr) begin
            mode_d    = mode_e'(in_cfg_mode);
            pattern_d = in_cfg_pattern;
            period_d  = in_cfg_period;
            duty_d    = in_cfg_duty;
            div_cnt_d = '0;
            seq_d     = in_cfg_pattern;
            phase_d   = 1'b0;
            pos_d     = '0;
            dir_d     = DIR_UP;
        end else if (period_q == '0) begin
            div_cnt_d = '0;
        end else if (step_due) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
            case (mode_q)
                ST_BLINK: begin
                    phase_d = ~phase_q;
                end
                ST_CHASE: begin
                    seq_d = {seq_q[N_LED-2:0], seq_q[N_LED-1]};
                end
                ST_BOUNCE: begin
                    // Ends are visited once: 0,1,..,5,4,..,1,0,1,..
                    if (dir_q == DIR_UP) begin
                        if (pos_q == POS_LAST) begin
                            dir_d = DIR_DOWN;
                            pos_d = pos_q - POS_W'(1);
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = DIR_UP;
                            pos_d = pos_q + POS_W'(1);
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end else begin
            div_cnt_d = div_cnt_q + PER_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output mux, evaluated on next-state so the register tracks the step
    // ------------------------------------------------------------------
    always_comb begin
        raw_d = '0;
        case (mode_d)
            ST_STATIC: raw_d = pattern_d;
            ST_BLINK:  raw_d = phase_d ? '0 : pattern_d;
            ST_CHASE:  raw_d = seq_d;
            ST_BOUNCE: raw_d = {{(N_LED-1){1'b0}}, 1'b1} << pos_d;
            default:   raw_d = '0;
        endcase
    end

`ifdef LED_SEQ_BRIGHT_EN
    logic [3:0] pwm_cnt_q, pwm_cnt_d;
    logic       pwm_on;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        pwm_on    = (duty_d == 4'hF) || (pwm_cnt_q < duty_d);
        led_d     = raw_d & {N_LED{pwm_on}};
    end
`else
    logic w_unused_duty;

    assign w_unused_duty = ^duty_q;

    always_comb begin
        led_d = raw_d;
    end
`endif

    assign out_led_mem = led_q;
    assign out_tick    = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_seq_ctrl
// Brief    : Scoreboard bench for led_seq_ctrl; expected {tick,led} values are
//            queued with each stimulus cycle and compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    localparam int PER_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_wr;
    logic [1:0]       cfg_mode;
    logic [5:0]       cfg_pattern;
    logic [PER_W-1:0] cfg_period;
    logic [3:0]       cfg_duty;
    logic [5:0]       led_mem;
    logic             tick;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];
    logic [2:0] bpos [10];

    led_seq_ctrl #(.PER_W(PER_W), .N_LED(6)) dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_cfg_wr     (cfg_wr),
        .in_cfg_mode   (cfg_mode),
        .in_cfg_pattern(cfg_pattern),
        .in_cfg_period (cfg_period),
        .in_cfg_duty   (cfg_duty),
        .out_led_mem   (led_mem),
        .out_tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; the expected result appears after the next edge.
    task automatic drive(input logic wr, input logic [1:0] mode, input logic [5:0] pat,
                         input logic [PER_W-1:0] per, input logic [3:0] duty,
                         input bit push, input string tag,
                         input logic [5:0] exp_led, input logic exp_tick);
        @(posedge clk);
        #2;
        cfg_wr = wr;
        if (wr) begin
            cfg_mode    = mode;
            cfg_pattern = pat;
            cfg_period  = per;
            cfg_duty    = duty;
        end
        if (push) begin
            exp_q.push_back({exp_tick, exp_led});
            tag_q.push_back(tag);
        end
    endtask

    task automatic idle(input string tag, input logic [5:0] exp_led, input logic exp_tick);
        drive(1'b0, 2'b00, 6'h00, '0, 4'h0, 1'b1, tag, exp_led, exp_tick);
    endtask

    always @(posedge clk) begin
        logic [6:0] e;
        string      t;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val(t, {1'b0, tick, led_mem}, {1'b0, e});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] chase_exp [6];
        int         on_cnt;

        bpos[0] = 3'd0; bpos[1] = 3'd1; bpos[2] = 3'd2; bpos[3] = 3'd3; bpos[4] = 3'd4;
        bpos[5] = 3'd5; bpos[6] = 3'd4; bpos[7] = 3'd3; bpos[8] = 3'd2; bpos[9] = 3'd1;
        chase_exp[0] = 6'b000110; chase_exp[1] = 6'b001100; chase_exp[2] = 6'b011000;
        chase_exp[3] = 6'b110000; chase_exp[4] = 6'b100001; chase_exp[5] = 6'b000011;

        rst = 1'b1; cfg_wr = 1'b0; cfg_mode = 2'b00; cfg_pattern = 6'h00;
        cfg_period = '0; cfg_duty = 4'h0;
        #3;
        check_val("reset_led",  {2'b00, led_mem}, 8'h00);
        check_val("reset_tick", {7'b0, tick},     8'h00);
        #14;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) idle("post_reset", 6'h00, 1'b0);

        // STATIC 2A, period 3: constant output, tick every third cycle
        drive(1'b1, 2'b00, 6'h2A, 16'd3, 4'hF, 1'b1, "static_wr", 6'h2A, 1'b0);
        for (int i = 1; i <= 9; i++) idle("static_run", 6'h2A, (i % 3) == 0);

        // CHASE 000011, period 1
        drive(1'b1, 2'b10, 6'b000011, 16'd1, 4'hF, 1'b1, "chase_wr", 6'b000011, 1'b0);
        for (int i = 0; i < 6; i++) idle("chase_run", chase_exp[i], 1'b1);

        // CHASE boundary patterns never change
        drive(1'b1, 2'b10, 6'h00, 16'd1, 4'hF, 1'b1, "chase_zero_wr", 6'h00, 1'b0);
        for (int i = 0; i < 3; i++) idle("chase_zero", 6'h00, 1'b1);
        drive(1'b1, 2'b10, 6'h3F, 16'd1, 4'hF, 1'b1, "chase_ones_wr", 6'h3F, 1'b0);
        for (int i = 0; i < 3; i++) idle("chase_ones", 6'h3F, 1'b1);

        // BOUNCE period 2 over more than two sweeps
        drive(1'b1, 2'b11, 6'h15, 16'd2, 4'hF, 1'b1, "bounce_wr", 6'h01, 1'b0);
        for (int i = 1; i <= 22; i++) begin
            logic [5:0] e;
            e = 6'h01 << bpos[(i / 2) % 10];
            idle("bounce_run", e, (i % 2) == 0);
        end
        // Period 0 mid-run: restart at 01 and freeze
        drive(1'b1, 2'b11, 6'h00, 16'd0, 4'hF, 1'b1, "bounce_pause_wr", 6'h01, 1'b0);
        for (int i = 0; i < 5; i++) idle("bounce_paused", 6'h01, 1'b0);

        // Async reset mid-BOUNCE
        drive(1'b1, 2'b11, 6'h00, 16'd1, 4'hF, 1'b1, "bounce_fast_wr", 6'h01, 1'b0);
        idle("bounce_fast", 6'h02, 1'b1);
        idle("bounce_fast", 6'h04, 1'b1);
        @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check_val("async_rst_led",  {2'b00, led_mem}, 8'h00);
        check_val("async_rst_tick", {7'b0, tick},     8'h00);
        #10;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) idle("after_rst", 6'h00, 1'b0);

        // BLINK 3F period 4; second write lands exactly when a tick is due
        drive(1'b1, 2'b01, 6'h3F, 16'd4, 4'hF, 1'b1, "blink_wr", 6'h3F, 1'b0);
        for (int i = 1; i <= 3; i++) idle("blink_pre", 6'h3F, 1'b0);
        drive(1'b1, 2'b01, 6'h3F, 16'd4, 4'hF, 1'b1, "blink_wr_on_tick", 6'h3F, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            logic [5:0] e;
            e = (((i / 4) % 2) == 1) ? 6'h00 : 6'h3F;
            idle("blink_run", e, (i % 4) == 0);
        end

        // Brightness gating on STATIC 3F
`ifdef LED_SEQ_BRIGHT_EN
        drive(1'b1, 2'b00, 6'h3F, 16'd0, 4'd4, 1'b0, "", 6'h00, 1'b0);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (led_mem == 6'h3F) on_cnt++;
            else check_val("duty4_level", {2'b00, led_mem}, 8'h00);
        end
        check_val("duty4_on_count", 8'(on_cnt), 8'd4);
        drive(1'b1, 2'b00, 6'h3F, 16'd0, 4'd0, 1'b1, "duty0_wr", 6'h00, 1'b0);
        for (int i = 0; i < 16; i++) idle("duty0", 6'h00, 1'b0);
`else
        on_cnt = 0;
        drive(1'b1, 2'b00, 6'h3F, 16'd0, 4'd4, 1'b1, "duty4_wr", 6'h3F, 1'b0);
        for (int i = 0; i < 16; i++) idle("duty4_ignored", 6'h3F, 1'b0);
        drive(1'b1, 2'b00, 6'h3F, 16'd0, 4'd0, 1'b1, "duty0_wr", 6'h3F, 1'b0);
        for (int i = 0; i < 16; i++) idle("duty0_ignored", 6'h3F, 1'b0);
`endif
        drive(1'b1, 2'b00, 6'h3F, 16'd0, 4'd15, 1'b1, "duty15_wr", 6'h3F, 1'b0);
        for (int i = 0; i < 16; i++) idle("duty15", 6'h3F, 1'b0);

        @(posedge clk);
        @(posedge clk);
        #3;
        check_val("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
